serial_lane_arbiter: RTL and testbench

- Sits downstream of two serial-to-parallel lane deserializers; each lane delivers one byte per strobe.
- Runs a per-lane comma-alignment FSM: a lane is declared synced after SYNC_CNT consecutive 0xBC commas.
- Once a lane is synced, commas are stripped and data bytes are buffered.
- Round-robin arbitration merges both lanes onto one registered valid/ready byte output tagged with its source lane.

---
 rtl/serial_lane_arbiter_if.sv | 27 ++
 rtl/serial_lane_arbiter.sv | 154 +++++++++++++++
 tb/tb_serial_lane_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_lane_arbiter_if.sv
// Bundle of lane inputs, lane controls and the merged valid/ready byte port
// shared by serial_lane_arbiter and whatever drives it.
interface serial_lane_arbiter_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] lane0_data;
    logic              lane0_strobe;
    logic [DATA_W-1:0] lane1_data;
    logic              lane1_strobe;
    logic [1:0]        lane_en;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_lane;
    logic              out_valid;
    logic [1:0]        lane_sync;
    logic [1:0]        overflow;

    modport master (
        output lane0_data, lane0_strobe, lane1_data, lane1_strobe, lane_en, out_ready,
        input  out_data, out_lane, out_valid, lane_sync, overflow
    );

    modport slave (
        input  lane0_data, lane0_strobe, lane1_data, lane1_strobe, lane_en, out_ready,
        output out_data, out_lane, out_valid, lane_sync, overflow
    );
endinterface

// File: rtl/serial_lane_arbiter.sv
// Two-lane comma aligner and comma stripper with a 1-deep holding register per
// lane, merged round-robin onto one registered valid/ready byte output.
module serial_lane_arbiter #(
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] COMMA    = 8'hBC,
    parameter int                SYNC_CNT = 4
) (
    input logic                  clk,
    input logic                  reset,
    serial_lane_arbiter_if.slave bus
);

    localparam logic [0:0] ST_SEARCH   = 1'b0;
    localparam logic [0:0] ST_ACTIVE   = 1'b1;
    localparam logic [3:0] SYNC_TARGET = 4'(SYNC_CNT);

    logic [DATA_W-1:0] laneData [2];
    logic [1:0]        laneStrobe;

    logic [0:0]        state_q    [2];
    logic [0:0]        state_d    [2];
    logic [3:0]        cnt_q      [2];
    logic [3:0]        cnt_d      [2];
    logic [DATA_W-1:0] holdData_q [2];
    logic [DATA_W-1:0] holdData_d [2];
    logic [1:0]        holdValid_q;
    logic [1:0]        holdValid_d;
    logic [1:0]        overflow_q;
    logic [1:0]        overflow_d;

    logic              lastGrant_q;
    logic              lastGrant_d;
    logic              outValid_q;
    logic              outValid_d;
    logic [DATA_W-1:0] outData_q;
    logic [DATA_W-1:0] outData_d;
    logic              outLane_q;
    logic              outLane_d;

    logic              outLoad;
    logic [1:0]        cand;
    logic [1:0]        grant;

    assign laneData[0]   = bus.lane0_data;
    assign laneData[1]   = bus.lane1_data;
    assign laneStrobe[0] = bus.lane0_strobe;
    assign laneStrobe[1] = bus.lane1_strobe;

    // A disabled lane is never a candidate, so a byte flushed by lane_en is never emitted.
    always_comb begin
        outLoad = !outValid_q || bus.out_ready;
        cand    = holdValid_q & bus.lane_en;
        grant   = 2'b00;
        if (outLoad) begin
            if (cand == 2'b11) begin
                grant = lastGrant_q ? 2'b01 : 2'b10;
            end else begin
                grant = cand;
            end
        end
    end

    always_comb begin
        outValid_d  = outValid_q;
        outData_d   = outData_q;
        outLane_d   = outLane_q;
        lastGrant_d = lastGrant_q;
        if (outLoad) begin
            outValid_d = |grant;
            if (grant[1]) begin
                outData_d   = holdData_q[1];
                outLane_d   = 1'b1;
                lastGrant_d = 1'b1;
            end else if (grant[0]) begin
                outData_d   = holdData_q[0];
                outLane_d   = 1'b0;
                lastGrant_d = 1'b0;
            end
        end
    end

    // The drain is applied before the fill so a granted register can take a new byte.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i]     = state_q[i];
            cnt_d[i]       = cnt_q[i];
            holdData_d[i]  = holdData_q[i];
            holdValid_d[i] = holdValid_q[i] & ~grant[i];
            overflow_d[i]  = overflow_q[i];

            if (!bus.lane_en[i]) begin
                state_d[i]     = ST_SEARCH;
                cnt_d[i]       = 4'd0;
                holdValid_d[i] = 1'b0;
            end else if (state_q[i] == ST_SEARCH) begin
                if (laneStrobe[i]) begin
                    if (laneData[i] == COMMA) begin
                        if (cnt_q[i] + 4'd1 == SYNC_TARGET) begin
                            state_d[i] = ST_ACTIVE;
                            cnt_d[i]   = 4'd0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 4'd1;
                        end
                    end else begin
                        cnt_d[i] = 4'd0;
                    end
                end
            end else if (laneStrobe[i] && (laneData[i] != COMMA)) begin
                if (holdValid_d[i]) begin
                    overflow_d[i] = 1'b1;
                end else begin
                    holdValid_d[i] = 1'b1;
                    holdData_d[i]  = laneData[i];
                end
            end
        end
    end

    // Pointer resets to "lane 1 granted last" so lane 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i]    <= ST_SEARCH;
                cnt_q[i]      <= 4'd0;
                holdData_q[i] <= '0;
            end
            holdValid_q <= 2'b00;
            overflow_q  <= 2'b00;
            lastGrant_q <= 1'b1;
            outValid_q  <= 1'b0;
            outData_q   <= '0;
            outLane_q   <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_q[i]    <= state_d[i];
                cnt_q[i]      <= cnt_d[i];
                holdData_q[i] <= holdData_d[i];
            end
            holdValid_q <= holdValid_d;
            overflow_q  <= overflow_d;
            lastGrant_q <= lastGrant_d;
            outValid_q  <= outValid_d;
            outData_q   <= outData_d;
            outLane_q   <= outLane_d;
        end
    end

    assign bus.out_valid = outValid_q;
    assign bus.out_data  = outData_q;
    assign bus.out_lane  = outLane_q;
    assign bus.lane_sync = {state_q[1] == ST_ACTIVE, state_q[0] == ST_ACTIVE};
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_serial_lane_arbiter.sv
// Bench for serial_lane_arbiter: directed scenarios plus a randomized run
// checked against a cycle-level behavioural model of the lanes and output port.
module tb_serial_lane_arbiter;

    localparam logic [7:0] COMMA    = 8'hBC;
    localparam int         SYNC_CNT = 4;

    logic clk;
    logic reset;

    serial_lane_arbiter_if #(.DATA_W(8)) bus ();

    serial_lane_arbiter #(
        .DATA_W  (8),
        .COMMA   (COMMA),
        .SYNC_CNT(SYNC_CNT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    bit [1:0] enV;
    bit       readyV;
    bit       resetV;

    // Reference model state: lane alignment, holding slots, output port.
    bit [1:0]   mSynced;
    int         mStreak [2];
    bit [1:0]   mFull;
    logic [7:0] mHoldByte [2];
    bit [1:0]   mOvf;
    bit         mValid;
    logic [7:0] mData;
    bit         mLane;
    int         mLast;

    task automatic modelEdge(input bit rst, input bit [1:0] en, input bit rdy,
                             input bit [1:0] stb, input logic [7:0] d0, input logic [7:0] d1);
        logic [7:0] byteIn [2];
        int winner;
        byteIn[0] = d0;
        byteIn[1] = d1;
        if (rst) begin
            mSynced = '0; mStreak[0] = 0; mStreak[1] = 0; mFull = '0; mOvf = '0;
            mValid = 1'b0; mData = '0; mLane = 1'b0; mLast = 1;
            return;
        end
        winner = -1;
        if (!mValid || rdy) begin
            if (mFull[0] && en[0] && mFull[1] && en[1]) winner = 1 - mLast;
            else if (mFull[0] && en[0]) winner = 0;
            else if (mFull[1] && en[1]) winner = 1;
            mValid = (winner >= 0);
            if (winner >= 0) begin
                mData = mHoldByte[winner];
                mLane = (winner == 1);
                mLast = winner;
                mFull[winner] = 1'b0;
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (!en[i]) begin
                mSynced[i] = 1'b0; mStreak[i] = 0; mFull[i] = 1'b0;
            end else if (stb[i]) begin
                if (!mSynced[i]) begin
                    if (byteIn[i] == COMMA) begin
                        mStreak[i]++;
                        if (mStreak[i] == SYNC_CNT) begin
                            mSynced[i] = 1'b1;
                            mStreak[i] = 0;
                        end
                    end else begin
                        mStreak[i] = 0;
                    end
                end else if (byteIn[i] != COMMA) begin
                    if (mFull[i]) mOvf[i] = 1'b1;
                    else begin
                        mFull[i] = 1'b1;
                        mHoldByte[i] = byteIn[i];
                    end
                end
            end
        end
    endtask

    task automatic applyStep(input bit s0, input logic [7:0] d0, input bit s1, input logic [7:0] d1);
        bus.lane0_strobe = s0;
        bus.lane0_data   = d0;
        bus.lane1_strobe = s1;
        bus.lane1_data   = d1;
        bus.lane_en      = enV;
        bus.out_ready    = readyV;
        reset            = resetV;
        @(posedge clk);
        modelEdge(resetV, enV, readyV, {s1, s0}, d0, d1);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStep(1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic doReset();
        resetV = 1'b1;
        idle(1);
        resetV = 1'b0;
    endtask

    task automatic syncLanes(input bit [1:0] mask, input int n);
        for (int k = 0; k < n; k++) applyStep(mask[0], COMMA, mask[1], COMMA);
    endtask

    task automatic test_reset();
        enV = 2'b00; readyV = 1'b0;
        doReset();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.out_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_data: got %h want 00", bus.out_data); end
        total++; if (bus.out_lane !== 1'b0) begin bad++; $display("[TB] FAIL reset_lane: got %b want 0", bus.out_lane); end
        total++; if (bus.lane_sync !== 2'b00) begin bad++; $display("[TB] FAIL reset_sync: got %b want 00", bus.lane_sync); end
        total++; if (bus.overflow !== 2'b00) begin bad++; $display("[TB] FAIL reset_ovf: got %b want 00", bus.overflow); end
    endtask

    task automatic test_sync();
        enV = 2'b11; readyV = 1'b1;
        doReset();
        syncLanes(2'b01, 3);
        total++; if (bus.lane_sync !== 2'b00) begin bad++; $display("[TB] FAIL sync_after3: got %b want 00", bus.lane_sync); end
        syncLanes(2'b01, 1);
        total++; if (bus.lane_sync !== 2'b01) begin bad++; $display("[TB] FAIL sync_after4: got %b want 01", bus.lane_sync); end
        doReset();
        syncLanes(2'b01, 2);
        applyStep(1'b1, 8'h12, 1'b0, 8'h00);
        syncLanes(2'b01, 3);
        total++; if (bus.lane_sync !== 2'b00) begin bad++; $display("[TB] FAIL sync_broken: got %b want 00", bus.lane_sync); end
        syncLanes(2'b01, 1);
        total++; if (bus.lane_sync !== 2'b01) begin bad++; $display("[TB] FAIL sync_resume: got %b want 01", bus.lane_sync); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL sync_no_output: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_pass_strip();
        enV = 2'b11; readyV = 1'b1;
        doReset();
        syncLanes(2'b01, 4);
        applyStep(1'b1, 8'h5A, 1'b0, 8'h00);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL pass_latency1: valid got %b want 0", bus.out_valid); end
        applyStep(1'b1, COMMA, 1'b0, 8'h00);
        total++; if ({bus.out_valid, bus.out_lane, bus.out_data} !== {1'b1, 1'b0, 8'h5A})
            begin bad++; $display("[TB] FAIL pass_first: got v%b l%b %h want v1 l0 5a", bus.out_valid, bus.out_lane, bus.out_data); end
        applyStep(1'b1, 8'hA5, 1'b0, 8'h00);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL pass_comma_stripped: valid got %b want 0", bus.out_valid); end
        idle(1);
        total++; if ({bus.out_valid, bus.out_lane, bus.out_data} !== {1'b1, 1'b0, 8'hA5})
            begin bad++; $display("[TB] FAIL pass_second: got v%b l%b %h want v1 l0 a5", bus.out_valid, bus.out_lane, bus.out_data); end
        idle(1);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL pass_drain: valid got %b want 0", bus.out_valid); end
    endtask

    task automatic test_round_robin();
        logic [7:0] expD [4];
        bit         expL [4];
        expD[0] = 8'h11; expL[0] = 1'b0;
        expD[1] = 8'h33; expL[1] = 1'b1;
        expD[2] = 8'h22; expL[2] = 1'b0;
        expD[3] = 8'h44; expL[3] = 1'b1;
        enV = 2'b11; readyV = 1'b1;
        doReset();
        syncLanes(2'b11, 4);
        total++; if (bus.lane_sync !== 2'b11) begin bad++; $display("[TB] FAIL rr_sync: got %b want 11", bus.lane_sync); end
        applyStep(1'b1, 8'h11, 1'b1, 8'h33);
        for (int k = 0; k < 4; k++) begin
            if (k == 1) applyStep(1'b1, 8'h22, 1'b1, 8'h44);
            else idle(1);
            total++;
            if ({bus.out_valid, bus.out_lane, bus.out_data} !== {1'b1, expL[k], expD[k]}) begin
                bad++;
                $display("[TB] FAIL rr_out%0d: got v%b l%b %h want v1 l%b %h", k, bus.out_valid, bus.out_lane, bus.out_data, expL[k], expD[k]);
            end
        end
        idle(1);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rr_drain: valid got %b want 0", bus.out_valid); end
        total++; if (bus.overflow !== 2'b00) begin bad++; $display("[TB] FAIL rr_ovf: got %b want 00", bus.overflow); end
    endtask

    task automatic test_backpressure();
        enV = 2'b11; readyV = 1'b0;
        doReset();
        syncLanes(2'b10, 4);
        applyStep(1'b0, 8'h00, 1'b1, 8'h01);
        applyStep(1'b0, 8'h00, 1'b1, 8'h02);
        total++; if ({bus.out_valid, bus.out_lane, bus.out_data} !== {1'b1, 1'b1, 8'h01})
            begin bad++; $display("[TB] FAIL bp_first: got v%b l%b %h want v1 l1 01", bus.out_valid, bus.out_lane, bus.out_data); end
        applyStep(1'b0, 8'h00, 1'b1, 8'h03);
        total++; if ({bus.out_valid, bus.out_data} !== {1'b1, 8'h01})
            begin bad++; $display("[TB] FAIL bp_hold_stable: got v%b %h want v1 01", bus.out_valid, bus.out_data); end
        total++; if (bus.overflow !== 2'b10) begin bad++; $display("[TB] FAIL bp_ovf: got %b want 10", bus.overflow); end
        readyV = 1'b1;
        idle(1);
        total++; if ({bus.out_valid, bus.out_lane, bus.out_data} !== {1'b1, 1'b1, 8'h02})
            begin bad++; $display("[TB] FAIL bp_second: got v%b l%b %h want v1 l1 02", bus.out_valid, bus.out_lane, bus.out_data); end
        idle(1);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_no_third: valid got %b want 0 (data %h)", bus.out_valid, bus.out_data); end
        total++; if (bus.overflow !== 2'b10) begin bad++; $display("[TB] FAIL bp_ovf_sticky: got %b want 10", bus.overflow); end
    endtask

    task automatic test_disable();
        enV = 2'b11; readyV = 1'b0;
        doReset();
        syncLanes(2'b01, 4);
        applyStep(1'b1, 8'h66, 1'b0, 8'h00);
        applyStep(1'b1, 8'h77, 1'b0, 8'h00);
        enV = 2'b10;
        idle(1);
        total++; if (bus.lane_sync !== 2'b00) begin bad++; $display("[TB] FAIL dis_sync: got %b want 00", bus.lane_sync); end
        total++; if ({bus.out_valid, bus.out_data} !== {1'b1, 8'h66})
            begin bad++; $display("[TB] FAIL dis_out_kept: got v%b %h want v1 66", bus.out_valid, bus.out_data); end
        enV = 2'b11; readyV = 1'b1;
        for (int k = 0; k < 3; k++) begin
            idle(1);
            total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL dis_flushed%0d: valid got %b data %h want valid 0", k, bus.out_valid, bus.out_data); end
        end
        syncLanes(2'b01, 3);
        total++; if (bus.lane_sync !== 2'b00) begin bad++; $display("[TB] FAIL dis_resync3: got %b want 00", bus.lane_sync); end
        syncLanes(2'b01, 1);
        total++; if (bus.lane_sync !== 2'b01) begin bad++; $display("[TB] FAIL dis_resync4: got %b want 01", bus.lane_sync); end
    endtask

    task automatic test_reset_mid();
        enV = 2'b11; readyV = 1'b0;
        doReset();
        syncLanes(2'b11, 4);
        applyStep(1'b1, 8'hAA, 1'b1, 8'hBB);
        applyStep(1'b1, 8'hCC, 1'b0, 8'h00);
        applyStep(1'b1, 8'hDD, 1'b0, 8'h00);
        total++; if ({bus.out_valid, bus.out_data, bus.overflow} !== {1'b1, 8'hAA, 2'b01})
            begin bad++; $display("[TB] FAIL mid_before: got v%b %h ovf %b want v1 aa ovf 01", bus.out_valid, bus.out_data, bus.overflow); end
        doReset();
        total++; if ({bus.out_valid, bus.out_lane, bus.out_data, bus.lane_sync, bus.overflow} !== 13'h0)
            begin bad++; $display("[TB] FAIL mid_cleared: got v%b l%b %h sync %b ovf %b want all 0", bus.out_valid, bus.out_lane, bus.out_data, bus.lane_sync, bus.overflow); end
        readyV = 1'b1;
        applyStep(1'b1, 8'h12, 1'b1, 8'h34);
        idle(2);
        total++; if ({bus.out_valid, bus.lane_sync} !== 3'b000)
            begin bad++; $display("[TB] FAIL mid_needs_resync: got v%b sync %b want v0 sync 00", bus.out_valid, bus.lane_sync); end
    endtask

    task automatic test_random();
        bit         s [2];
        logic [7:0] d [2];
        enV = 2'b11; readyV = 1'b1;
        doReset();
        for (int n = 0; n < 800; n++) begin
            resetV = ($urandom_range(0, 249) == 0);
            readyV = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 2; i++) begin
                enV[i] = ($urandom_range(0, 31) != 0);
                s[i]   = ($urandom_range(0, 1) == 1);
                if ($urandom_range(0, 99) < (mSynced[i] ? 25 : 80)) d[i] = COMMA;
                else d[i] = 8'($urandom_range(0, 255));
            end
            applyStep(s[0], d[0], s[1], d[1]);
            resetV = 1'b0;
            total++;
            if (bus.out_valid !== mValid) begin
                bad++; $display("[TB] FAIL rand_valid@%0d: got %b want %b", n, bus.out_valid, mValid);
            end
            if (mValid) begin
                total++;
                if ({bus.out_lane, bus.out_data} !== {mLane, mData}) begin
                    bad++; $display("[TB] FAIL rand_data@%0d: got l%b %h want l%b %h", n, bus.out_lane, bus.out_data, mLane, mData);
                end
            end
            total++;
            if ({bus.lane_sync, bus.overflow} !== {mSynced, mOvf}) begin
                bad++; $display("[TB] FAIL rand_status@%0d: got sync %b ovf %b want sync %b ovf %b", n, bus.lane_sync, bus.overflow, mSynced, mOvf);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        resetV = 1'b1; enV = 2'b00; readyV = 1'b0;
        bus.lane0_data = '0; bus.lane0_strobe = 1'b0;
        bus.lane1_data = '0; bus.lane1_strobe = 1'b0;
        bus.lane_en = 2'b00; bus.out_ready = 1'b0;
        mHoldByte[0] = '0; mHoldByte[1] = '0;
        modelEdge(1'b1, 2'b00, 1'b0, 2'b00, 8'h00, 8'h00);
        resetV = 1'b0;
        test_reset();
        test_sync();
        test_pass_strip();
        test_round_robin();
        test_backpressure();
        test_disable();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
